// File: rtl/spi_pkg.sv
// Shared types for the SPI clock/chip-select generator: FSM state encoding
// and the transfer configuration captured when a request is accepted.
package spi_pkg;

  // Upper bounds for the latched config fields. The top zero-extends its
  // parameterised inputs into these and reads back only the low bits.
  localparam int CS_MAX_W  = 4;
  localparam int CNT_MAX_W = 16;
  localparam int DIV_MAX_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEAD = 3'd1,
    RUN  = 3'd2,
    LAG  = 3'd3,
    FIN  = 3'd4
  } spi_state_t;

  typedef struct packed {
    logic [CS_MAX_W-1:0]  cs_sel;
    logic [CNT_MAX_W-1:0] nbits;
    logic [DIV_MAX_W-1:0] div;
    logic [DIV_MAX_W-1:0] cs_lead;
    logic [DIV_MAX_W-1:0] cs_lag;
    logic                 cpol;
    logic                 cpha;
  } spi_cfg_t;

endpackage

// File: rtl/spi_half_period_cnt.sv
// Half-period counter for the SPI clock. Counts 0..div_i while enabled and
// wraps back to 0; tc_o marks the last cycle of each half-period.
module spi_half_period_cnt
  import spi_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] div_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  assign tc_o = en_i && (cnt_q == div_i);

  // Clear on reset/load, otherwise count up and wrap at the divider value.
  always_ff @(posedge clk_i) begin
    if (rst_i || load_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      if (cnt_q == div_i) cnt_q <= '0;
      else                cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI master clock and chip-select sequencer. Generates sclk, active-low
// chip selects with programmable setup/hold, and per-bit shift/sample strobes.
//
// state | meaning
// IDLE  | waiting for start; sclk follows live cpol
// LEAD  | chip select asserted, cs_lead+1 cycles of setup before sclk runs
// RUN   | 2*nbits half-periods of div+1 cycles, sclk toggles at each end
// LAG   | sclk parked at cpol, chip select held for cs_lag+1 cycles
// FIN   | one cycle, chip selects released, done pulse
module spi_sclk_gen #(
  parameter int N_CS  = 4,
  parameter int DIV_W = 8,
  parameter int CNT_W = 6,
  localparam int CS_W = (N_CS > 1) ? $clog2(N_CS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CS_W-1:0]  cs_sel,
  input  logic [CNT_W-1:0] nbits,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] cs_lead,
  input  logic [DIV_W-1:0] cs_lag,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             dft_test_mode,
  output logic             sclk,
  output logic [N_CS-1:0]  cs_n,
  output logic             shift_en,
  output logic             sample_en,
  output logic             busy,
  output logic             done
);

  import spi_pkg::*;

  spi_state_t       state_q, state_d;
  spi_cfg_t         cfg_q, cfg_d;
  logic [DIV_W-1:0] timer_q, timer_d;
  logic [CNT_W:0]   edge_q, edge_d;
  logic             sclk_q, sclk_d;
  logic             shift_q, shift_d;
  logic             sample_q, sample_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N_CS-1:0]  cs_n_q, cs_n_d;

  logic             hp_tc;
  logic             kill;
  logic             cfg_valid;
  logic             edge_lead;
  logic             edge_last;
  logic [CNT_W:0]   last_edge;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_lag;
  logic             unused_cfg;

  assign cfg_div   = cfg_q.div[DIV_W-1:0];
  assign cfg_lag   = cfg_q.cs_lag[DIV_W-1:0];
  assign last_edge = {cfg_q.nbits[CNT_W-1:0], 1'b0} - (CNT_W+1)'(1);
  assign edge_lead = ~edge_q[0];
  assign edge_last = (edge_q == last_edge);
  // Test mode and abort both drop the block straight back to idle.
  assign kill      = dft_test_mode || (abort && (state_q != IDLE));
  assign cfg_valid = (nbits != '0) && (int'(cs_sel) < N_CS);
  // Only the low bits of the wide config fields are meaningful here.
  assign unused_cfg = ^cfg_q;

  spi_half_period_cnt #(
    .W (DIV_W)
  ) u_hp_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (state_q != RUN),
    .en_i   (state_q == RUN),
    .div_i  (cfg_div),
    .tc_o   (hp_tc)
  );

  // Next-state, timer, edge counter, sclk and strobe computation.
  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    timer_d  = timer_q;
    edge_d   = edge_q;
    sclk_d   = sclk_q;
    shift_d  = 1'b0;
    sample_d = 1'b0;

    if (kill) begin
      state_d = IDLE;
      timer_d = '0;
      edge_d  = '0;
      sclk_d  = (state_q == IDLE) ? cpol : cfg_q.cpol;
    end else begin
      case (state_q)
        IDLE: begin
          sclk_d = cpol;
          if (start) begin
            cfg_d.cs_sel  = CS_MAX_W'(cs_sel);
            cfg_d.nbits   = CNT_MAX_W'(nbits);
            cfg_d.div     = DIV_MAX_W'(div);
            cfg_d.cs_lead = DIV_MAX_W'(cs_lead);
            cfg_d.cs_lag  = DIV_MAX_W'(cs_lag);
            cfg_d.cpol    = cpol;
            cfg_d.cpha    = cpha;
            edge_d        = '0;
            // Empty or unaddressable transfers finish without touching the bus.
            if (cfg_valid) begin
              state_d = LEAD;
              timer_d = cs_lead;
            end else begin
              state_d = FIN;
            end
          end
        end
        LEAD: begin
          if (timer_q == '0) state_d = RUN;
          else               timer_d = timer_q - DIV_W'(1);
        end
        RUN: begin
          if (hp_tc) begin
            sclk_d = ~sclk_q;
            // Strobes are registered with the toggle, so they line up with
            // the first cycle at the new sclk level.
            if (cfg_q.cpha) begin
              shift_d  = edge_lead;
              sample_d = ~edge_lead;
            end else begin
              sample_d = edge_lead;
              shift_d  = ~edge_lead && ~edge_last;
            end
            if (edge_last) begin
              state_d = LAG;
              edge_d  = '0;
              timer_d = cfg_lag;
            end else begin
              edge_d = edge_q + (CNT_W+1)'(1);
            end
          end
        end
        LAG: begin
          if (timer_q == '0) state_d = FIN;
          else               timer_d = timer_q - DIV_W'(1);
        end
        FIN: begin
          state_d = IDLE;
          sclk_d  = cfg_q.cpol;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output decode from the next state so cs_n/busy/done register alongside it.
  always_comb begin
    cs_n_d = '1;
    if ((state_d == LEAD) || (state_d == RUN) || (state_d == LAG)) begin
      for (int i = 0; i < N_CS; i++) begin
        if (int'(cfg_d.cs_sel) == i) cs_n_d[i] = 1'b0;
      end
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  // State and registered outputs; reset also clears the latched config.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cfg_q    <= '0;
      timer_q  <= '0;
      edge_q   <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= '1;
      shift_q  <= 1'b0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      timer_q  <= timer_d;
      edge_q   <= edge_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sclk      = sclk_q;
  assign cs_n      = cs_n_q;
  assign shift_en  = shift_q;
  assign sample_en = sample_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
